// File: rtl/vram_pkg.sv
// Shared types for the screen VRAM arbiter: write entry, clear FSM states, grant codes.
// Latency: n/a (types only).
// Backpressure: n/a.
package vram_pkg;

    localparam int VRAM_AW = 15;

    typedef struct packed {
        logic [VRAM_AW-1:0] addr;
        logic [7:0]         data;
    } vram_wr_t;

    typedef enum logic [1:0] {
        CLR_IDLE,
        CLR_RUN,
        CLR_LAST
    } clr_state_t;

    typedef enum logic [2:0] {
        G_NONE,
        G_VID,
        G_CPU,
        G_LD,
        G_CLR
    } grant_t;

endpackage

// File: rtl/vram_arbiter_if.sv
// Requester, control and VRAM-macro signals of the screen VRAM arbiter.
// Latency: n/a (wiring only).
// Backpressure: cpu_full / ld_ready / clr_busy flow from slave to master.
interface vram_arbiter_if #(
    parameter int ADDR_W = 15
);
    logic              vid_req;
    logic [ADDR_W-1:0] vid_addr;
    logic [7:0]        vid_dout;
    logic              vid_valid;

    logic              cpu_we;
    logic [ADDR_W-1:0] cpu_addr;
    logic [7:0]        cpu_din;
    logic              cpu_full;
    logic              cpu_ovf;

    logic              ld_valid;
    logic [ADDR_W-1:0] ld_addr;
    logic [7:0]        ld_data;
    logic              ld_ready;

    logic              clr_start;
    logic [7:0]        clr_value;
    logic              clr_busy;

    logic [ADDR_W-1:0] ram_addr;
    logic              ram_we;
    logic [7:0]        ram_din;
    logic [7:0]        ram_dout;

    // Requesters plus the VRAM macro, seen from outside the arbiter.
    modport master (
        output vid_req, vid_addr, cpu_we, cpu_addr, cpu_din,
               ld_valid, ld_addr, ld_data, clr_start, clr_value, ram_dout,
        input  vid_dout, vid_valid, cpu_full, cpu_ovf, ld_ready, clr_busy,
               ram_addr, ram_we, ram_din
    );

    // The arbiter itself.
    modport slave (
        input  vid_req, vid_addr, cpu_we, cpu_addr, cpu_din,
               ld_valid, ld_addr, ld_data, clr_start, clr_value, ram_dout,
        output vid_dout, vid_valid, cpu_full, cpu_ovf, ld_ready, clr_busy,
               ram_addr, ram_we, ram_din
    );

endinterface

// File: rtl/wr_fifo.sv
// Synchronous FIFO of buffered CPU screen writes.
// Latency: an entry pushed into an empty FIFO is visible at the head next cycle.
// Backpressure: registered full; a push while full is dropped and flagged on drop_o.
module wr_fifo
    import vram_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic     clk_i,
    input  logic     rst_n_i,
    input  logic     push_i,
    input  vram_wr_t push_dat_i,
    input  logic     pop_i,
    output vram_wr_t head_o,
    output logic     empty_o,
    output logic     full_o,
    output logic     drop_o
);
    localparam int            PW       = $clog2(DEPTH);
    localparam logic [PW:0]   FULL_CNT = (PW+1)'(DEPTH);

    vram_wr_t      mem_q [DEPTH];
    logic [PW-1:0] wptr_q, rptr_q;
    logic [PW:0]   count_q, count_d;
    logic          full_q, empty_q;
    logic          push_ok, pop_ok;

    // Full is judged on the registered flag so a same-cycle pop never rescues a push.
    assign push_ok = push_i & ~full_q;
    assign pop_ok  = pop_i & ~empty_q;
    assign drop_o  = push_i & full_q;
    assign head_o  = mem_q[rptr_q];
    assign empty_o = empty_q;
    assign full_o  = full_q;

    // Occupancy next-state.
    always_comb begin
        count_d = count_q;
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + (PW+1)'(1);
            2'b01:   count_d = count_q - (PW+1)'(1);
            default: count_d = count_q;
        endcase
    end

    // Pointers, count and registered status flags.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
            full_q  <= 1'b0;
            empty_q <= 1'b1;
        end else begin
            if (push_ok) wptr_q <= wptr_q + PW'(1);
            if (pop_ok)  rptr_q <= rptr_q + PW'(1);
            count_q <= count_d;
            full_q  <= (count_d == FULL_CNT);
            empty_q <= (count_d == '0);
        end
    end

    // Entry storage; contents are don't-care while the slot is unoccupied.
    always_ff @(posedge clk_i) begin
        if (push_ok) mem_q[wptr_q] <= push_dat_i;
    end

endmodule

// File: rtl/vram_arbiter.sv
// Single-port screen VRAM arbiter: video > starved loader > CPU FIFO > loader > clear.
// Latency: video read data 2 cycles after vid_req, fixed; writes complete in their grant cycle.
// Backpressure: cpu_full (drops + sticky cpu_ovf), ld_ready grant strobe, clr_busy.
module vram_arbiter
    import vram_pkg::*;
#(
    parameter int ADDR_W       = 15,
    parameter int FIFO_DEPTH   = 4,
    parameter int STARVE_LIMIT = 8
) (
    input  logic           clk_sys,
    input  logic           nRESET,
    vram_arbiter_if.slave  bus
);
    localparam int           SW         = $clog2(STARVE_LIMIT + 1);
    localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);

    grant_t            grant;
    vram_wr_t          fifo_in, fifo_head;
    logic              fifo_empty, fifo_full, fifo_drop;

    logic [SW-1:0]     starve_q, starve_d;
    logic              starved;

    clr_state_t        clr_state_q, clr_state_d;
    logic [ADDR_W-1:0] clr_ptr_q, clr_ptr_d;
    logic [7:0]        clr_val_q, clr_val_d;

    logic [ADDR_W-1:0] addr_q, ram_addr_c;
    logic              ram_we_c;
    logic [7:0]        ram_din_c;
    logic              vid_p1_q, vid_valid_q, ovf_q;
    logic [7:0]        vid_dout_q;

    assign fifo_in = '{addr: VRAM_AW'(bus.cpu_addr), data: bus.cpu_din};

    wr_fifo #(.DEPTH(FIFO_DEPTH)) u_wr_fifo (
        .clk_i      (clk_sys),
        .rst_n_i    (nRESET),
        .push_i     (bus.cpu_we),
        .push_dat_i (fifo_in),
        .pop_i      (grant == G_CPU),
        .head_o     (fifo_head),
        .empty_o    (fifo_empty),
        .full_o     (fifo_full),
        .drop_o     (fifo_drop)
    );

    assign starved = (starve_q == STARVE_MAX);

    // Fixed-priority grant; nothing is granted while reset is asserted.
    always_comb begin
        grant = G_NONE;
        if (!nRESET)                       grant = G_NONE;
        else if (bus.vid_req)              grant = G_VID;
        else if (bus.ld_valid && starved)  grant = G_LD;
        else if (!fifo_empty)              grant = G_CPU;
        else if (bus.ld_valid)             grant = G_LD;
        else if (clr_state_q == CLR_RUN)   grant = G_CLR;
    end

    // VRAM port mux; the address parks on its last value when nobody is granted.
    always_comb begin
        ram_addr_c = addr_q;
        ram_we_c   = 1'b0;
        ram_din_c  = '0;
        case (grant)
            G_VID: ram_addr_c = bus.vid_addr;
            G_CPU: begin
                ram_addr_c = ADDR_W'(fifo_head.addr);
                ram_din_c  = fifo_head.data;
                ram_we_c   = 1'b1;
            end
            G_LD: begin
                ram_addr_c = bus.ld_addr;
                ram_din_c  = bus.ld_data;
                ram_we_c   = 1'b1;
            end
            G_CLR: begin
                ram_addr_c = clr_ptr_q;
                ram_din_c  = clr_val_q;
                ram_we_c   = 1'b1;
            end
            default: ;
        endcase
    end

    // Loader starvation counter: counts denied cycles, saturates, clears on grant.
    always_comb begin
        starve_d = starve_q;
        if (grant == G_LD)                 starve_d = '0;
        else if (bus.ld_valid && !starved) starve_d = starve_q + SW'(1);
    end

    // Clear FSM next-state: sweep every address once, then one LAST cycle before IDLE.
    always_comb begin
        clr_state_d = clr_state_q;
        clr_ptr_d   = clr_ptr_q;
        clr_val_d   = clr_val_q;
        case (clr_state_q)
            CLR_IDLE: if (bus.clr_start) begin
                clr_state_d = CLR_RUN;
                clr_ptr_d   = '0;
                clr_val_d   = bus.clr_value;
            end
            CLR_RUN: if (grant == G_CLR) begin
                clr_ptr_d = clr_ptr_q + ADDR_W'(1);
                if (clr_ptr_q == '1) clr_state_d = CLR_LAST;
            end
            CLR_LAST: clr_state_d = CLR_IDLE;
            default:  clr_state_d = CLR_IDLE;
        endcase
    end

    // State registers: video pipeline, parked address, overflow flag, starvation, clear FSM.
    always_ff @(posedge clk_sys) begin
        if (!nRESET) begin
            addr_q      <= '0;
            vid_p1_q    <= 1'b0;
            vid_valid_q <= 1'b0;
            vid_dout_q  <= '0;
            ovf_q       <= 1'b0;
            starve_q    <= '0;
            clr_state_q <= CLR_IDLE;
            clr_ptr_q   <= '0;
            clr_val_q   <= '0;
        end else begin
            addr_q      <= ram_addr_c;
            vid_p1_q    <= (grant == G_VID);
            vid_valid_q <= vid_p1_q;
            if (vid_p1_q) vid_dout_q <= bus.ram_dout;
            if (fifo_drop) ovf_q <= 1'b1;
            starve_q    <= starve_d;
            clr_state_q <= clr_state_d;
            clr_ptr_q   <= clr_ptr_d;
            clr_val_q   <= clr_val_d;
        end
    end

    assign bus.ram_addr  = ram_addr_c;
    assign bus.ram_we    = ram_we_c;
    assign bus.ram_din   = ram_din_c;
    assign bus.vid_dout  = vid_dout_q;
    assign bus.vid_valid = vid_valid_q;
    assign bus.cpu_full  = fifo_full;
    assign bus.cpu_ovf   = ovf_q;
    assign bus.ld_ready  = (grant == G_LD);
    assign bus.clr_busy  = (clr_state_q != CLR_IDLE);

endmodule

// File: tb/tb_vram_arbiter.sv
// Directed bench for vram_arbiter with a behavioural 1-cycle synchronous VRAM.
// Inputs change 1 time unit after the rising edge; outputs are sampled on the falling edge.
module tb_vram_arbiter;
    localparam int AW = 15;

    logic clk_sys = 1'b0;
    logic nRESET;
    logic preload;

    vram_arbiter_if #(.ADDR_W(AW)) bus ();

    vram_arbiter #(.ADDR_W(AW), .FIFO_DEPTH(4), .STARVE_LIMIT(8)) dut (
        .clk_sys (clk_sys),
        .nRESET  (nRESET),
        .bus     (bus)
    );

    always #5 clk_sys = ~clk_sys;

    // VRAM model
    logic [7:0] mem [0:32767];
    always @(posedge clk_sys) begin
        if (preload)          mem[15'h1800] <= 8'hA5;
        else if (bus.ram_we)  mem[bus.ram_addr] <= bus.ram_din;
        bus.ram_dout <= mem[bus.ram_addr];
    end

    // Write / video monitors
    typedef struct packed {
        logic [14:0] addr;
        logic [7:0]  data;
        logic [31:0] cyc;
    } wr_rec_t;

    wr_rec_t wq[$];
    int      cyc_cnt = 0;
    int      vid_cnt = 0;

    always @(posedge clk_sys) cyc_cnt <= cyc_cnt + 1;

    always @(negedge clk_sys) begin
        if (bus.ram_we) wq.push_back('{bus.ram_addr, bus.ram_din, 32'(cyc_cnt)});
        if (bus.vid_valid) vid_cnt <= vid_cnt + 1;
    end

    int n_chk = 0;
    int n_err = 0;

    task automatic expect_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_sys);
        #1;
    endtask

    task automatic sample();
        @(negedge clk_sys);
    endtask

    task automatic idle_inputs();
        bus.vid_req   = 1'b0; bus.vid_addr = '0;
        bus.cpu_we    = 1'b0; bus.cpu_addr = '0; bus.cpu_din = '0;
        bus.ld_valid  = 1'b0; bus.ld_addr  = '0; bus.ld_data = '0;
        bus.clr_start = 1'b0; bus.clr_value = '0;
    endtask

    initial begin
        int b, c0, v0, busy, bad;
        bit done;
        int gq[$];

        idle_inputs();
        nRESET  = 1'b0;
        preload = 1'b1;
        repeat (3) tick();
        preload = 1'b0;
        sample();
        expect_eq("rst_ram_we",    32'(bus.ram_we),    0);
        expect_eq("rst_ram_addr",  32'(bus.ram_addr),  0);
        expect_eq("rst_vid_valid", 32'(bus.vid_valid), 0);
        expect_eq("rst_vid_dout",  32'(bus.vid_dout),  0);
        expect_eq("rst_cpu_full",  32'(bus.cpu_full),  0);
        expect_eq("rst_cpu_ovf",   32'(bus.cpu_ovf),   0);
        expect_eq("rst_clr_busy",  32'(bus.clr_busy),  0);
        expect_eq("rst_ld_ready",  32'(bus.ld_ready),  0);
        tick();
        nRESET = 1'b1;
        repeat (2) tick();

        // 1: single video fetch, 2-cycle latency
        v0 = vid_cnt;
        bus.vid_req = 1'b1; bus.vid_addr = 15'h1800;
        sample();
        expect_eq("t1_we",       32'(bus.ram_we),    0);
        expect_eq("t1_addr",     32'(bus.ram_addr),  32'h1800);
        expect_eq("t1_valid_n0", 32'(bus.vid_valid), 0);
        tick(); bus.vid_req = 1'b0; bus.vid_addr = '0;
        sample();
        expect_eq("t1_valid_n1", 32'(bus.vid_valid), 0);
        expect_eq("t1_addr_park", 32'(bus.ram_addr), 32'h1800);
        tick(); sample();
        expect_eq("t1_valid_n2", 32'(bus.vid_valid), 1);
        expect_eq("t1_dout",     32'(bus.vid_dout),  32'hA5);
        tick(); sample();
        expect_eq("t1_valid_n3", 32'(bus.vid_valid), 0);
        repeat (3) tick();
        expect_eq("t1_valid_count", 32'(vid_cnt - v0), 1);

        // 2: five back-to-back CPU writes drain one per cycle, in order
        b = wq.size(); c0 = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            bus.cpu_we = 1'b1; bus.cpu_addr = 15'(100 + i); bus.cpu_din = 8'(8'h10 + i);
            if (i == 0) c0 = cyc_cnt;
            sample();
            if (i == 0) expect_eq("t2_first_nowrite", 32'(bus.ram_we), 0);
        end
        tick(); bus.cpu_we = 1'b0;
        repeat (5) tick();
        expect_eq("t2_count", 32'(wq.size() - b), 5);
        for (int i = 0; i < 5 && (b + i) < wq.size(); i++) begin
            expect_eq("t2_addr", 32'(wq[b+i].addr), 32'(100 + i));
            expect_eq("t2_data", 32'(wq[b+i].data), 32'(8'h10 + i));
            expect_eq("t2_cyc",  wq[b+i].cyc,       32'(c0 + 1 + i));
        end
        expect_eq("t2_ovf", 32'(bus.cpu_ovf), 0);

        // 3: video hogs the port, FIFO fills, 5th/6th writes dropped
        b = wq.size();
        for (int k = 0; k < 20; k++) begin
            tick();
            bus.vid_req = 1'b1; bus.vid_addr = '0;
            bus.cpu_we = (k < 6); bus.cpu_addr = 15'(200 + k); bus.cpu_din = 8'(8'h20 + k);
            sample();
            if (k == 3)  expect_eq("t3_not_full_yet", 32'(bus.cpu_full), 0);
            if (k == 4)  expect_eq("t3_full",         32'(bus.cpu_full), 1);
            if (k == 19) begin
                expect_eq("t3_we_stalled", 32'(bus.ram_we),  0);
                expect_eq("t3_ovf",        32'(bus.cpu_ovf), 1);
            end
        end
        tick(); bus.vid_req = 1'b0; bus.cpu_we = 1'b0;
        repeat (8) tick();
        expect_eq("t3_count", 32'(wq.size() - b), 4);
        for (int i = 0; i < 4 && (b + i) < wq.size(); i++) begin
            expect_eq("t3_addr", 32'(wq[b+i].addr), 32'(200 + i));
            expect_eq("t3_data", 32'(wq[b+i].data), 32'(8'h20 + i));
        end
        sample();
        expect_eq("t3_full_clear", 32'(bus.cpu_full), 0);

        // 4: loader starved by continuous CPU traffic
        for (int k = 0; k < 40; k++) begin
            tick();
            bus.cpu_we = (k < 36); bus.cpu_addr = 15'(300 + k); bus.cpu_din = 8'(k);
            bus.ld_valid = (k >= 2 && k < 22); bus.ld_addr = 15'h4000; bus.ld_data = 8'h77;
            sample();
            if (bus.ld_ready) begin
                gq.push_back(k - 2);
                expect_eq("t4_ld_addr", 32'(bus.ram_addr), 32'h4000);
                expect_eq("t4_ld_data", 32'(bus.ram_din),  32'h77);
            end
        end
        expect_eq("t4_grants", 32'(gq.size()), 2);
        if (gq.size() >= 1) expect_eq("t4_first_grant",  32'(gq[0]), 8);
        if (gq.size() >= 2) expect_eq("t4_second_grant", 32'(gq[1]), 17);
        tick(); bus.cpu_we = 1'b0; bus.ld_valid = 1'b1;
        sample();
        expect_eq("t4_ld_free", 32'(bus.ld_ready), 1);
        tick(); bus.ld_valid = 1'b0;
        repeat (2) tick();

        // 5: full-screen clear, second start ignored
        b = wq.size();
        bus.clr_start = 1'b1; bus.clr_value = 8'h38;
        sample();
        expect_eq("t5_busy_start", 32'(bus.clr_busy), 0);
        busy = 0; done = 1'b0;
        for (int k = 0; k < 40000 && !done; k++) begin
            tick();
            bus.clr_start = (k == 1000);
            bus.clr_value = (k == 1000) ? 8'h11 : 8'h38;
            sample();
            if (bus.clr_busy) busy++;
            else done = 1'b1;
        end
        expect_eq("t5_done",   32'(done), 1);
        expect_eq("t5_busy",   32'(busy), 32769);
        expect_eq("t5_writes", 32'(wq.size() - b), 32768);
        bad = 0;
        for (int i = 0; (b + i) < wq.size(); i++)
            if (wq[b+i].addr != 15'(i) || wq[b+i].data != 8'h38) bad++;
        expect_eq("t5_bad_writes", 32'(bad), 0);
        expect_eq("t5_we_idle", 32'(bus.ram_we), 0);

        // 6: reset mid-clear with three buffered CPU writes
        b = wq.size();
        tick();
        bus.vid_req = 1'b1; bus.clr_start = 1'b1; bus.clr_value = 8'h55;
        for (int k = 0; k < 4; k++) begin
            tick();
            bus.clr_start = 1'b0;
            bus.cpu_we = (k < 3); bus.cpu_addr = 15'(500 + k); bus.cpu_din = 8'(k);
        end
        sample();
        expect_eq("t6_busy_pre", 32'(bus.clr_busy), 1);
        expect_eq("t6_full_pre", 32'(bus.cpu_full), 0);
        tick();
        nRESET = 1'b0; bus.vid_req = 1'b0; bus.cpu_we = 1'b0;
        sample();
        expect_eq("t6_rst_we", 32'(bus.ram_we), 0);
        tick();
        nRESET = 1'b1;
        sample();
        expect_eq("t6_busy",  32'(bus.clr_busy), 0);
        expect_eq("t6_full",  32'(bus.cpu_full), 0);
        expect_eq("t6_we",    32'(bus.ram_we),   0);
        expect_eq("t6_ovf",   32'(bus.cpu_ovf),  0);
        repeat (10) tick();
        expect_eq("t6_no_writes", 32'(wq.size() - b), 0);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
